// File: rtl/shift_sequencer.sv
// Multi-cycle 4-bit shift/rotate sequencer: accepts a job in IDLE, applies one
// single-bit step per cycle in RUN, and pulses DONE for one cycle in FIN.
module shift_sequencer (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic [3:0] D,
   input  logic [1:0] MODE,
   input  logic [1:0] CNT,
   output logic [3:0] Q,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] FIN  = 2'b10;

   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ROL = 2'b10;

   logic [1:0] state;
   logic [1:0] r;
   logic [1:0] m;
   logic [3:0] q;

   function automatic logic [3:0] step(input logic [3:0] v, input logic [1:0] md);
      logic [3:0] res;
      case (md)
         MODE_LSL: res = {v[2:0], 1'b0};
         MODE_LSR: res = {1'b0, v[3:1]};
         MODE_ROL: res = {v[2:0], v[3]};
         default:  res = {v[0], v[3:1]};
      endcase
      return res;
   endfunction

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         q     <= 4'b0000;
         r     <= 2'd0;
         m     <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  q     <= D;
                  r     <= CNT;
                  m     <= MODE;
                  state <= RUN;
               end
            end
            RUN: begin
               // Counter reaching zero ends the job; the zero test also keeps r from wrapping.
               if (r != 2'd0) begin
                  q <= step(q, m);
                  r <= r - 2'd1;
               end else begin
                  state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign Q    = q;
   assign BUSY = (state == RUN);
   assign DONE = (state == FIN);

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have no parameters; the data width is fixed at 4 bits and the shift count at 2 bits (0..3 steps).
REQ-002 SHALL have port CLK, input, 1 bit: the only clock, rising edge active.
REQ-003 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port START, input, 1 bit: request a shift job, sampled only in IDLE.
REQ-005 SHALL have port D, input, 4 bits: operand, captured on the accepting edge.
REQ-006 SHALL have port MODE, input, 2 bits: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right; captured on the accepting edge.
REQ-007 SHALL have port CNT, input, 2 bits: number of single-bit steps, captured on the accepting edge.
REQ-008 SHALL have port Q, output, 4 bits: working register and result.
REQ-009 SHALL have port BUSY, output, 1 bit: high while in RUN.
REQ-010 SHALL have port DONE, output, 1 bit: single-cycle completion pulse.

Function
REQ-011 SHALL implement three states, IDLE, RUN and FIN, encoded in registers clocked by CLK.
REQ-012 In IDLE with START=1, a rising edge SHALL load Q<=D, R<=CNT and M<=MODE, and move to RUN.
REQ-013 In IDLE with START=0, the state and Q SHALL hold.
REQ-014 In RUN with R!=0, each edge SHALL apply one step to Q using latched M and decrement R by 1.
REQ-015 In RUN with R==0, the edge SHALL move to FIN with Q unchanged.
REQ-016 FIN SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 Step definitions, where Q=q3q2q1q0, SHALL be:
- LSL gives q2q1q0 0
- LSR gives 0 q3q2q1
- ROL gives q2q1q0q3
- ROR gives q0q3q2q1
REQ-018 Latency SHALL be as follows, with e0 the accepting edge:
- RUN is occupied for CNT+1 cycles.
- DONE is high in the cycle after edge e(CNT+1).
- The earliest next accept is edge e(CNT+3).
REQ-019 BUSY SHALL be 1 only in RUN, and DONE SHALL be 1 only in FIN; both SHALL be decoded from registered state without glitching combinational inputs.
REQ-020 START, D, MODE and CNT SHALL be ignored in RUN and FIN; changing them mid-job SHALL NOT alter the result.
REQ-021 START held high continuously SHALL start a new job on every IDLE cycle, giving back-to-back jobs with one IDLE cycle between them.
REQ-022 With CNT=0, Q at DONE SHALL equal D.
REQ-023 Q SHALL hold the final result from FIN until the next accepting edge.
REQ-024 The step counter R SHALL never wrap below 0.

Reset
REQ-025 RST_N=0 SHALL immediately force state=IDLE, Q=4'b0000, R=0, M=00, BUSY=0 and DONE=0, regardless of CLK.
REQ-026 Reset asserted in RUN or FIN SHALL abort the job with no DONE pulse, and Q SHALL read 0000.
REQ-027 After RST_N rises, the first edge with START=1 SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover LSL by one step: D=1000, MODE=00, CNT=1, START pulse -> DONE in the cycle after e2, Q=0000, BUSY high for 2 cycles.
REQ-029 The bench SHALL cover ROL by three steps: D=0100, MODE=10, CNT=3 -> Q sequence 0100, 1000, 0001, 0010, then DONE with Q=0010 after e4.
REQ-030 The bench SHALL cover LSR by two steps with input changes mid-job: D=1100, MODE=01, CNT=2, and D changed to 1111 and MODE to 11 during RUN -> Q=0011 at DONE.
REQ-031 The bench SHALL cover ROR by one step followed by a continuously held START: D=1010, MODE=11, CNT=1 -> Q=0101 at DONE; next accept exactly one IDLE cycle after FIN.
REQ-032 The bench SHALL cover a zero-count job: D=1010, CNT=0 -> BUSY for 1 cycle, DONE after e1, Q=1010.
REQ-033 The bench SHALL cover reset mid-job: RST_N pulled low during RUN of a CNT=3 job, between clock edges -> Q=0000, BUSY=0 and DONE=0 at once, no DONE afterward.
